dc_mem_bridge: RTL
==================

# dc_mem_bridge

Memory-side bridge placed directly downstream of the data-cache tile unit. It accepts the cache's memory port requests (128-bit tile or single 32-bit DWORD, load or store), sequences them as 32-bit beats on the external memory bus, and returns data and status over the `memPcOK` handshake. Responses follow the cache's tile state machine: one `OK` pulse per transaction, and `HOLD` while busy.

## Interface
- `TIMEOUT`, 255: bus wait cycles per beat before the transfer aborts with FAULT (1..255, held in an 8-bit counter).
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `memPcAddr`  in  32  request address from cache.
- `memInData`  in  128  store data from cache (cache `memOutData`).
- `memPcOE`  in  1  load request.
- `memPcWR`  in  1  store request.
- `memPcOp`  in  5  1 = tile (4 DWORD), 2 = single DWORD; all other values are invalid.
- `memPcData`  out  128  load data to cache.
- `memPcOK`  out  2  status: 00 READY, 01 OK, 10 HOLD, 11 FAULT (UMEM_OK_* encoding).
- `busAddr`  out  32  DWORD-aligned bus address.
- `busOutData`  out  32  bus write data.
- `busInData`  in  32  bus read data.
- `busOE`  out  1  bus read strobe.
- `busWR`  out  1  bus write strobe.
- `busOK`  in  2  bus status, same encoding; a beat completes on OK; FAULT aborts.

## Operation
- States: IDLE, BEAT, RESP, TURN.
- **IDLE**
  - `memPcOK`=READY.
  - On `(memPcOE|memPcWR)`: latch addr, data, op and direction; clear the beat index and timeout counter.
  - Valid request (op 1 or 2, exactly one of OE/WR set): go to BEAT.
  - Otherwise: set status=FAULT and go to RESP.
- **BEAT**
  - `memPcOK`=HOLD.
  - `busOE`/`busWR` are asserted per the latched direction.
  - Tile address: `busAddr={addr[31:4],beat[1:0],2'b00}`. DWORD address: `{addr[31:2],2'b00}`.
  - Write data: tile `busOutData=memInData[32*beat+31:32*beat]`; DWORD uses `[31:0]`.
  - `busOK`==OK:
    - On a read, store `busInData` into lane `beat` of the read register. A DWORD read goes to lane 0, with lanes 1–3 cleared to 0.
    - Increment `beat` and clear the timeout counter.
    - If this was the last beat (beat 3 for tile, beat 0 for DWORD), set status=OK and go to RESP.
  - `busOK`==FAULT, or timeout counter reaches `TIMEOUT`: set status=FAULT, abort the remaining beats, go to RESP.
  - Otherwise the timeout counter increments.
- **RESP**
  - `memPcOK`=status for exactly one cycle; strobes are low.
  - Go to TURN.
- **TURN**
  - `memPcOK`=READY for one cycle; strobes are low; new requests are ignored.
  - Go to IDLE.
- Inputs are ignored after acceptance. The cache holds its request stable until it sees OK.
- `memPcData` is the registered read buffer. It is updated only by read beats and holds its value until the next read overwrites it. Stores and FAULT responses do not modify it.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `memPcOK`=00, `memPcData`=0, `busAddr`=0, `busOutData`=0, `busOE`=0, `busWR`=0.
- Asserting reset at any time, including mid-beat, drops the strobes immediately and returns the bridge to IDLE. A partial tile is discarded.
- Zero-wait DWORD:
  - cycle 0: accept
  - cycle 1: strobe, `busOK`=OK
  - cycle 2: `memPcOK`=OK, `memPcData` valid
  - cycle 3: READY
  - cycle 4: next accept possible
- Zero-wait tile:
  - beats on cycles 1–4
  - OK on cycle 5
  - next accept on cycle 7
- Each wait cycle on the bus adds one cycle. The strobe stays high across beats; the address advances on the cycle after each beat's OK.
- Timeout: FAULT is signalled `TIMEOUT`+1 cycles after a beat starts without an ack.

## Test plan
- **DWORD read:** OE=1, op=2, addr=0x00001238; bus returns 0xDEADBEEF with zero wait.
  - `busAddr`=0x00001238 on cycle 1.
  - `memPcOK`=01 on cycle 2 only, then READY.
  - `memPcData`=0x...00000000DEADBEEF.
- **Tile read:** addr=0x00002004, op=1; bus returns 0x11, 0x22, 0x33, 0x44.
  - `busAddr` sequence is 0x2000, 0x2004, 0x2008, 0x200C.
  - `memPcData`={0x44,0x33,0x22,0x11}.
  - OK on cycle 5.
- **Tile write with wait states:** memInData=0xA..D lanes; bus inserts 2 HOLD cycles on beat 1.
  - `busOutData` per beat is 0xA, 0xB, 0xC, 0xD.
  - Beat 1 is held for 3 cycles.
  - OK on cycle 7.
  - `memPcData` is unchanged.
- **Error cases:**
  - op=3 → FAULT on cycle 1, no strobe.
  - OE=WR=1 → FAULT, no strobe.
  - `busOK`=FAULT on tile beat 2 → strobes drop, `memPcOK`=11 for one cycle.
- **Timeout:** `TIMEOUT`=4, bus never acks → FAULT on cycle 6; the bridge then accepts a fresh DWORD read normally.
- **Reset mid-tile:** reset is asserted during beat 2.
  - Same cycle: strobes=0, `memPcOK`=00.
  - After release: IDLE, and the next request completes correctly.

Source files
------------

// File: rtl/dc_mem_bridge.sv
// Purpose: turns data-cache tile/DWORD memory requests into a sequence of 32-bit beats on the external bus.
// Latency: zero-wait DWORD gives OK 2 cycles after accept; zero-wait tile gives OK 5 cycles after accept; each bus wait adds 1 cycle.
// Backpressure: memPcOK shows HOLD while beats are in flight. Bus HOLD stalls the current beat. Bus FAULT or a TIMEOUT-cycle stall aborts the transfer with FAULT.
module dc_mem_bridge #(
    parameter int TIMEOUT = 255
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [31:0]  memPcAddr,
    input  logic [127:0] memInData,
    input  logic         memPcOE,
    input  logic         memPcWR,
    input  logic [4:0]   memPcOp,
    output logic [127:0] memPcData,
    output logic [1:0]   memPcOK,
    output logic [31:0]  busAddr,
    output logic [31:0]  busOutData,
    input  logic [31:0]  busInData,
    output logic         busOE,
    output logic         busWR,
    input  logic [1:0]   busOK
);

    localparam logic [1:0] OK_READY = 2'b00;
    localparam logic [1:0] OK_OK    = 2'b01;
    localparam logic [1:0] OK_HOLD  = 2'b10;
    localparam logic [1:0] OK_FAULT = 2'b11;
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BEAT, RESP, TURN} state_t;

    state_t       state, stateNext;
    logic [31:2]  addrQ;
    logic [127:0] dataQ;
    logic         tileQ;
    logic         readQ;
    logic [1:0]   beat;
    logic [7:0]   waitCnt;
    // The first three tile lanes are staged here. memPcData is then written once, on the final beat, so an aborted tile leaves it untouched.
    logic [31:0]  rdLane0, rdLane1, rdLane2;

    logic         reqSeen, reqValid, reqTile;
    logic         beatOk, beatFail, lastBeat;
    logic [1:0]   nextBeat;
    logic         unusedAddrBits;

    // Bus addresses are always DWORD aligned, so the byte offset is not needed.
    assign unusedAddrBits = ^memPcAddr[1:0];

    assign reqSeen  = memPcOE | memPcWR;
    assign reqTile  = (memPcOp == 5'd1);
    assign reqValid = (reqTile || memPcOp == 5'd2) && (memPcOE ^ memPcWR);
    assign beatOk   = (busOK == OK_OK);
    assign beatFail = (busOK == OK_FAULT) || (waitCnt == TIMEOUT_CNT);
    assign lastBeat = !tileQ || (beat == 2'd3);
    assign nextBeat = beat + 2'd1;

    function automatic logic [31:0] beatAddr(input logic [31:2] a, input logic tile, input logic [1:0] b);
        return tile ? {a[31:4], b, 2'b00} : {a, 2'b00};
    endfunction

    function automatic logic [31:0] laneOf(input logic [127:0] d, input logic [1:0] b);
        return d[{b, 5'b00000} +: 32];
    endfunction

    // State register; reset drops the bridge back to IDLE at any point, discarding a partial tile.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    // Next-state decision for the request/beat/response sequence.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (reqSeen) stateNext = reqValid ? BEAT : RESP;
            BEAT: begin
                if (beatOk) begin
                    if (lastBeat) stateNext = RESP;
                end else if (beatFail) begin
                    stateNext = RESP;
                end
            end
            RESP:    stateNext = TURN;
            TURN:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Registered datapath: request latch, beat sequencing, bus strobes, status and read buffer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addrQ      <= '0;
            dataQ      <= '0;
            tileQ      <= 1'b0;
            readQ      <= 1'b0;
            beat       <= 2'd0;
            waitCnt    <= 8'd0;
            rdLane0    <= '0;
            rdLane1    <= '0;
            rdLane2    <= '0;
            memPcData  <= '0;
            memPcOK    <= OK_READY;
            busAddr    <= '0;
            busOutData <= '0;
            busOE      <= 1'b0;
            busWR      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (reqSeen) begin
                        addrQ   <= memPcAddr[31:2];
                        dataQ   <= memInData;
                        tileQ   <= reqTile;
                        readQ   <= memPcOE;
                        beat    <= 2'd0;
                        waitCnt <= 8'd0;
                        if (reqValid) begin
                            memPcOK    <= OK_HOLD;
                            busOE      <= memPcOE;
                            busWR      <= memPcWR;
                            busAddr    <= beatAddr(memPcAddr[31:2], reqTile, 2'd0);
                            busOutData <= memInData[31:0];
                        end else begin
                            memPcOK <= OK_FAULT;
                        end
                    end
                end
                BEAT: begin
                    if (beatOk) begin
                        if (readQ) begin
                            if (!tileQ) begin
                                memPcData <= {96'd0, busInData};
                            end else begin
                                case (beat)
                                    2'd0:    rdLane0 <= busInData;
                                    2'd1:    rdLane1 <= busInData;
                                    2'd2:    rdLane2 <= busInData;
                                    default: memPcData <= {busInData, rdLane2, rdLane1, rdLane0};
                                endcase
                            end
                        end
                        beat    <= nextBeat;
                        waitCnt <= 8'd0;
                        if (lastBeat) begin
                            memPcOK <= OK_OK;
                            busOE   <= 1'b0;
                            busWR   <= 1'b0;
                        end else begin
                            busAddr    <= beatAddr(addrQ, tileQ, nextBeat);
                            busOutData <= laneOf(dataQ, nextBeat);
                        end
                    end else if (beatFail) begin
                        memPcOK <= OK_FAULT;
                        busOE   <= 1'b0;
                        busWR   <= 1'b0;
                    end else begin
                        waitCnt <= waitCnt + 8'd1;
                    end
                end
                RESP:    memPcOK <= OK_READY;
                default: memPcOK <= OK_READY;
            endcase
        end
    end

endmodule
